// File: rtl/aidan_mcnay_prime_seq.sv
// ---------------------------------------------------------------------------
// aidan_mcnay_prime_seq
//
// Decides whether an nbits-wide unsigned number N is prime by trial division.
// Each remainder N mod d is computed by an external iterative divider, which
// this block drives over val/rdy streams with one transaction outstanding at
// a time. The trial divisors are 2, 3, 5, 7, 9, ... and the search stops once
// d*d exceeds N.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   num, istream_val,   number to test (input stream)
//   istream_rdy
//   is_prime, factor,   result stream: factor is the smallest divisor found,
//   ostream_val,        or 0 when N is prime or N < 2
//   ostream_rdy
//   div_opa, div_opb,   divider request: dividend N, divisor d
//   div_istream_val,
//   div_istream_rdy
//   div_result,         divider response: remainder
//   div_ostream_val,
//   div_ostream_rdy
// ---------------------------------------------------------------------------
module aidan_mcnay_prime_seq #(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] num,
  input  logic             istream_val,
  output logic             istream_rdy,
  output logic             is_prime,
  output logic [nbits-1:0] factor,
  output logic             ostream_val,
  input  logic             ostream_rdy,
  output logic [nbits-1:0] div_opa,
  output logic [nbits-1:0] div_opb,
  output logic             div_istream_val,
  input  logic             div_istream_rdy,
  input  logic [nbits-1:0] div_result,
  input  logic             div_ostream_val,
  output logic             div_ostream_rdy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [nbits-1:0] n_reg;
  logic [nbits-1:0] n_next;
  logic [nbits-1:0] d_reg;
  logic [nbits-1:0] d_next;
  logic             prime_next;
  logic [nbits-1:0] factor_next;
  logic [2*nbits-1:0] d_sq;
  logic             sq_gt_n;

  // After 2 only odd candidates are tried.
  function automatic logic [nbits-1:0] next_divisor(input logic [nbits-1:0] d);
    return (d == nbits'(2)) ? nbits'(3) : d + nbits'(2);
  endfunction

  // Square is formed at double width so it never wraps, even for the last
  // divisor that overshoots sqrt(N).
  assign d_sq    = {{nbits{1'b0}}, d_reg} * {{nbits{1'b0}}, d_reg};
  assign sq_gt_n = d_sq > {{nbits{1'b0}}, n_reg};

  assign div_opa = n_reg;
  assign div_opb = d_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_reg    <= '0;
      d_reg    <= '0;
      is_prime <= 1'b0;
      factor   <= '0;
    end else begin
      n_reg    <= n_next;
      d_reg    <= d_next;
      is_prime <= prime_next;
      factor   <= factor_next;
    end
  end

  always_comb begin
    state_next      = state;
    n_next          = n_reg;
    d_next          = d_reg;
    prime_next      = is_prime;
    factor_next     = factor;
    istream_rdy     = 1'b0;
    ostream_val     = 1'b0;
    div_istream_val = 1'b0;
    div_ostream_rdy = 1'b0;

    case (state)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) begin
          n_next = num;
          d_next = nbits'(2);
          // N is 0 or 1: not prime, no division needed.
          if (num[nbits-1:1] == '0) begin
            prime_next  = 1'b0;
            factor_next = '0;
            state_next  = DONE;
          end else begin
            state_next = CHECK;
          end
        end
      end

      CHECK: begin
        if (sq_gt_n) begin
          prime_next  = 1'b1;
          factor_next = '0;
          state_next  = DONE;
        end else begin
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        div_istream_val = 1'b1;
        if (div_istream_rdy) begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        div_ostream_rdy = 1'b1;
        if (div_ostream_val) begin
          if (div_result == '0) begin
            prime_next  = 1'b0;
            factor_next = d_reg;
            state_next  = DONE;
          end else begin
            d_next     = next_divisor(d_reg);
            state_next = CHECK;
          end
        end
      end

      DONE: begin
        ostream_val = 1'b1;
        if (ostream_rdy) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/aidan_mcnay_prime_seq.md
Name: aidan_mcnay_prime_seq

Overview:
Sequencer that decides whether an nbits-wide unsigned number is prime by trial division. It drives the iterative remainder divider (opa mod opb) through the divider's val/rdy streams, one transaction at a time. Trial divisors run 2, 3, 5, 7, 9, … while d*d <= N. It reports is_prime and the smallest factor found on a latency-insensitive output stream, and sits between the top-level number source and the divider.

Parameters:
nbits, 16, width of the tested number, the divisor and the divider operands

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
num  input  nbits  number N to test
istream_val  input  1  num valid
istream_rdy  output  1  block ready to accept num
is_prime  output  1  1 = N is prime
factor  output  nbits  smallest divisor found; 0 when is_prime=1 or N<2
ostream_val  output  1  is_prime/factor valid
ostream_rdy  input  1  consumer ready
div_opa  output  nbits  divider dividend (always captured N)
div_opb  output  nbits  divider divisor (current trial d)
div_istream_val  output  1  divider request valid
div_istream_rdy  input  1  divider ready for request
div_result  input  nbits  divider remainder
div_ostream_val  input  1  divider remainder valid
div_ostream_rdy  output  1  block ready for remainder

Behaviour:
- Clock is clk. Reset is asynchronous and active-high; the port is named reset.
- A transfer fires on a cycle where val && rdy are both high, on every stream.
- States: IDLE, CHECK, ISSUE, WAIT, DONE.
- Reset forces IDLE immediately, without waiting for a clock edge. During reset: n_reg=0, d_reg=0, is_prime=0, factor=0, ostream_val=0, div_istream_val=0, div_ostream_rdy=0.
- Reset mid-operation drops the operation. The divider shares the same reset, so no stale remainder is ever consumed.
- IDLE: istream_rdy=1, all other handshake outputs 0.
  - On input fire: capture N into n_reg, set d_reg=2.
  - If N<2: set is_prime=0, factor=0, go to DONE.
  - Otherwise go to CHECK.
- CHECK (exactly 1 cycle):
  - Compute d_reg*d_reg at 2*nbits width; it must not wrap.
  - If the square > n_reg: set is_prime=1, factor=0, go to DONE.
  - Otherwise go to ISSUE.
- ISSUE: div_istream_val=1, div_opa=n_reg, div_opb=d_reg, all held stable until fire. On fire, go to WAIT.
- WAIT: div_ostream_rdy=1. On fire:
  - If div_result==0: set is_prime=0, factor=d_reg, go to DONE.
  - Otherwise: d_reg = 3 if d_reg==2, else d_reg+2; go to CHECK.
- Divisor range: d_reg never exceeds floor(sqrt(2^nbits-1))+2, so the nbits-wide d_reg cannot overflow.
- DONE:
  - ostream_val=1; is_prime and factor are registered and held stable.
  - istream_rdy=0, so no new input is accepted.
  - On output fire, go to IDLE. While ostream_rdy=0, stay in DONE indefinitely.
- div_istream_val is high only in ISSUE; div_ostream_rdy is high only in WAIT. At most one divider transaction is outstanding.
- Minimum latency:
  - N<2: 1 cycle from input fire to ostream_val.
  - N=2 or 3: 2 cycles (no divider transaction).
  - Each trial divisor adds 1 (CHECK) + ISSUE wait + divider latency.
- Divider stalls (div_istream_rdy or div_ostream_val held low) only extend ISSUE or WAIT; they cause no state or data change.
- Inputs num/istream_val are ignored outside IDLE.

Test Plan:
- N=0, then N=1 -> DONE after 1 cycle, is_prime=0, factor=0, zero divider requests. N=2 -> is_prime=1, factor=0, zero divider requests.
- N=97 with a real divider model -> divisors issued 2,3,5,7,9 (5 transactions), is_prime=1, factor=0. N=91 -> divisors 2,3,5,7; is_prime=0, factor=7. N=4 -> one transaction (d=2), factor=2.
- N=65521 (largest 16-bit prime) -> divisors run up to 255, is_prime=1, no d or square overflow. N=65535 -> factor=3, is_prime=0.
- Backpressure:
  - Hold ostream_rdy=0 for 10 cycles after N=91 completes -> ostream_val, is_prime=0, factor=7 stay stable, istream_rdy=0.
  - Random div_istream_rdy/div_ostream_val stalls -> same results as the unstalled run.
- Assert reset mid-WAIT while testing N=9991 -> outputs clear immediately (before the next clk edge), state returns to IDLE. The next input N=13 yields is_prime=1 with divisors 2,3 only.
- Back-to-back inputs 25, 29 with ostream_rdy=1 -> results (0,5) then (1,0). istream_rdy reasserts the cycle after output fire.
